rom_fill_ctrl: RTL and testbench
================================

Name: rom_fill_ctrl

Overview:
Instruction-cache refill controller between the core's ROM cache and the external instruction memory bridge. On a cache miss it latches the line base address and fetches one full cache line word by word over a req/ack bus. It then presents the assembled line with a one-cycle store strobe so the cache captures it and the core's fetch stall clears. One fill is in flight at a time; the core stalls for the whole fill.

Parameters:
LINE_WORDS_LOG2, 2, log2 of 32-bit words per cache line (same value as the cache's word-address size); LINE_WORDS = 2**LINE_WORDS_LOG2.
CNT_W, 16, width of the completed-fill counter.

Ports:
clk  in  1  core clock; all logic on posedge.
reset  in  1  asynchronous, active-high reset.
miss_req  in  1  cache miss from the core (rom_re); high while the cache misses at miss_addr.
miss_addr  in  32  byte address of the missing fetch (rom_addr).
line_data  out  32*LINE_WORDS  assembled line; word k at bits [32k+31:32k].
line_valid  out  1  one-cycle store strobe to the cache (rom_oe).
mem_req  out  1  word read request to the memory bridge.
mem_addr  out  32  word-aligned byte address of the requested word.
mem_ack  in  1  bridge acknowledge; mem_rdata is valid in the ack cycle.
mem_rdata  in  32  read data.
busy  out  1  high in any state other than IDLE.
fill_count  out  CNT_W  number of completed fills; wraps modulo 2**CNT_W.

Behaviour:
- Reset (async, on assertion): state=IDLE; mem_req=0, mem_addr=0, line_valid=0, busy=0, fill_count=0, line_data=0, word index=0. A fill in progress is abandoned; mem_req drops immediately without waiting for mem_ack. An ack arriving after reset release is ignored in IDLE.
- Address rules: base = {miss_addr[31:LINE_WORDS_LOG2+2], zeros}. Word k address = base + 4*k. Address arithmetic wraps modulo 2**32.
- IDLE: when miss_req=1, latch base, set index=0, go to FETCH. This cycle is the first cycle of the fill.
- FETCH:
  - mem_req=1 and mem_addr=base+4*index, held stable until mem_ack.
  - On mem_ack: write mem_rdata into slot index and increment index.
  - If the acked index was LINE_WORDS-1, go to DONE with mem_req=0 next cycle. Otherwise the next word is requested in the following cycle.
  - Back-to-back acks give one word per cycle. mem_ack while mem_req=0 is ignored.
  - Changes to miss_req or miss_addr during FETCH are ignored; the fill completes for the latched base.
- DONE: line_valid=1 for exactly one cycle with line_data stable. fill_count increments. Go to RECOVER.
- RECOVER: one cycle in which miss_req is ignored while the cache hit propagates. Then go to IDLE; a miss still asserted in IDLE starts a new fill.
- line_data holds its last value outside fills. Slots are overwritten only by acks.
- Latency with zero-wait acks, from the miss_req sample in IDLE to line_valid: LINE_WORDS+1 cycles. With W wait cycles per word: LINE_WORDS*(W+1)+1 cycles.
- All outputs are registered; none depends combinationally on any input.
- State encoding: IDLE, FETCH, DONE, RECOVER. Unreachable encodings go to IDLE.

Test Plan:
- Single fill, zero-wait acks:
  - Stimulus: miss_addr=0x8000_0014.
  - Required: mem_addr sequence 0x8000_0010, _14, _18, _1C on 4 consecutive cycles; line_valid 5 cycles after the miss sample; line_data words equal the returned data; fill_count=1.
- Wait states:
  - Stimulus: ack 3 cycles after each request; miss_addr=0x0000_0000.
  - Required: mem_addr is stable while waiting; line_valid at cycle 17; busy is high throughout until IDLE.
- Address change mid-fill:
  - Stimulus: miss_addr switches to 0x8000_0100 after word 1.
  - Required: remaining words still use base 0x8000_0010; no second fill starts before RECOVER completes.
- Reset mid-fill:
  - Stimulus: assert reset while word 2 is pending.
  - Required: mem_req=0 and fill_count=0 asynchronously; a late ack after release is ignored; a new miss restarts at word 0.
- Back-to-back misses:
  - Stimulus: miss_req held high across the fill, then a second miss at 0x8000_0020.
  - Required: exactly one line_valid per fill; the second fill starts in the IDLE cycle after RECOVER; fill_count=2.
- Counter wrap and address wrap:
  - Stimulus: preload by running 2**CNT_W fills, or use CNT_W=2 in the bench; miss at 0xFFFF_FFF8.
  - Required: fill_count wraps to 0; mem_addr sequence 0xFFFF_FFF0, _F4, _F8, _FC.

Source files
------------

// File: rtl/rom_fill_ctrl_if.sv
// Signal bundle between the refill controller, the ROM cache/core side and the
// instruction memory bridge.
interface rom_fill_ctrl_if #(
  parameter int unsigned LINE_WORDS_LOG2 = 2,
  parameter int unsigned CNT_W           = 16
);
  localparam int unsigned LINE_WORDS = 1 << LINE_WORDS_LOG2;

  logic                      miss_req;
  logic [31:0]               miss_addr;
  logic [32*LINE_WORDS-1:0]  line_data;
  logic                      line_valid;
  logic                      mem_req;
  logic [31:0]               mem_addr;
  logic                      mem_ack;
  logic [31:0]               mem_rdata;
  logic                      busy;
  logic [CNT_W-1:0]          fill_count;

  modport master (
    input  miss_req, miss_addr, mem_ack, mem_rdata,
    output line_data, line_valid, mem_req, mem_addr, busy, fill_count
  );

  modport slave (
    output miss_req, miss_addr, mem_ack, mem_rdata,
    input  line_data, line_valid, mem_req, mem_addr, busy, fill_count
  );
endinterface

// File: rtl/rom_fill_ctrl.sv
// Instruction-cache refill controller: fetches one aligned line word by word
// over a req/ack bus and presents it with a one-cycle store strobe.
module rom_fill_ctrl #(
  parameter int unsigned LINE_WORDS_LOG2 = 2,
  parameter int unsigned CNT_W           = 16
) (
  input logic           clk,
  input logic           reset,
  rom_fill_ctrl_if.master bus
);
  localparam int unsigned LINE_WORDS = 1 << LINE_WORDS_LOG2;
  localparam int unsigned OFS_W      = LINE_WORDS_LOG2 + 2;
  localparam logic [31:0] BASE_MASK  = {{(32-OFS_W){1'b1}}, {OFS_W{1'b0}}};

  typedef enum logic [1:0] {IDLE, FETCH, DONE, RECOVER} state_e;

  state_e                             state_q, state_d;
  logic [31:0]                        base_q, base_d;
  logic [LINE_WORDS_LOG2-1:0]         idx_q, idx_d;
  logic                               mem_req_q, mem_req_d;
  logic [31:0]                        mem_addr_q, mem_addr_d;
  logic                               line_valid_q, line_valid_d;
  logic                               busy_q, busy_d;
  logic [CNT_W-1:0]                   fill_count_q, fill_count_d;
  logic [LINE_WORDS-1:0][31:0]        line_q, line_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      base_q       <= '0;
      idx_q        <= '0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      line_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      fill_count_q <= '0;
      line_q       <= '0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      idx_q        <= idx_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      line_valid_q <= line_valid_d;
      busy_q       <= busy_d;
      fill_count_q <= fill_count_d;
      line_q       <= line_d;
    end
  end

  // Outputs are registered, so every *_d describes what the next state presents.
  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    idx_d        = idx_q;
    mem_req_d    = 1'b0;
    line_valid_d = 1'b0;
    fill_count_d = fill_count_q;
    line_d       = line_q;

    case (state_q)
      IDLE: begin
        if (bus.miss_req) begin
          base_d    = bus.miss_addr & BASE_MASK;
          idx_d     = '0;
          mem_req_d = 1'b1;
          state_d   = FETCH;
        end
      end
      FETCH: begin
        mem_req_d = 1'b1;
        if (bus.mem_ack) begin
          line_d[idx_q] = bus.mem_rdata;
          idx_d         = idx_q + 1'b1;
          if (idx_q == '1) begin
            mem_req_d    = 1'b0;
            line_valid_d = 1'b1;
            fill_count_d = fill_count_q + 1'b1;
            state_d      = DONE;
          end
        end
      end
      DONE:    state_d = RECOVER;
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    mem_addr_d = mem_req_d ? (base_d + 32'({idx_d, 2'b00})) : mem_addr_q;
    busy_d     = (state_d != IDLE);
  end

  assign bus.mem_req    = mem_req_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.line_valid = line_valid_q;
  assign bus.busy       = busy_q;
  assign bus.fill_count = fill_count_q;
  assign bus.line_data  = line_q;
endmodule

// File: tb/tb_rom_fill_ctrl.sv
// Directed and randomized checks of rom_fill_ctrl against a line-level model
// built from the address, latency and handshake rules.
module tb_rom_fill_ctrl;
  localparam int LW2 = 2;
  localparam int LW  = 1 << LW2;
  localparam int CW  = 2;

  logic clk = 1'b0;
  logic reset;

  rom_fill_ctrl_if #(.LINE_WORDS_LOG2(LW2), .CNT_W(CW)) bus ();
  rom_fill_ctrl #(.LINE_WORDS_LOG2(LW2), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  logic [CW-1:0] exp_cnt;
  logic [31:0]   exp_line [LW];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] exp_packed();
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < LW; k++) r[32*k +: 32] = exp_line[k];
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One full fill. wt<0 picks a random wait per word; chg moves miss_addr
  // after word 1; hold keeps miss_req high past the fill.
  task automatic do_fill(input logic [31:0] addr, input int wt, input bit chg, input bit hold);
    logic [31:0] base;
    int w;
    base = addr & ~32'(4*LW - 1);
    bus.miss_req  = 1'b1;
    bus.miss_addr = addr;
    chk("idle_busy", bus.busy, 0);
    step();
    for (int k = 0; k < LW; k++) begin
      w = (wt < 0) ? int'($urandom_range(0, 3)) : wt;
      for (int j = 0; j <= w; j++) begin
        chk("mem_req", bus.mem_req, 1);
        chk("mem_addr", bus.mem_addr, base + 32'(4*k));
        chk("busy_fetch", bus.busy, 1);
        chk("lv_fetch", bus.line_valid, 0);
        bus.mem_ack   = (j == w);
        bus.mem_rdata = $urandom;
        if (j == w) exp_line[k] = bus.mem_rdata;
        step();
      end
      if (chg && k == 1) bus.miss_addr = 32'h8000_0100;
    end
    exp_cnt++;
    chk("line_valid", bus.line_valid, 1);
    chk("line_data", bus.line_data, exp_packed());
    chk("fill_count", bus.fill_count, exp_cnt);
    chk("req_done", bus.mem_req, 0);
    chk("busy_done", bus.busy, 1);
    if (!hold) bus.miss_req = 1'b0;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = $urandom;
    step();
    chk("lv_recover", bus.line_valid, 0);
    chk("busy_recover", bus.busy, 1);
    chk("req_recover", bus.mem_req, 0);
    chk("data_recover", bus.line_data, exp_packed());
    chk("cnt_recover", bus.fill_count, exp_cnt);
    step();
    chk("busy_idle", bus.busy, 0);
    chk("req_idle", bus.mem_req, 0);
    chk("lv_idle", bus.line_valid, 0);
    chk("data_idle", bus.line_data, exp_packed());
    bus.mem_ack = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    bus.miss_req  = 1'b0;
    bus.miss_addr = '0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    exp_cnt       = '0;
    for (int k = 0; k < LW; k++) exp_line[k] = '0;
    repeat (3) @(negedge clk);
    chk("rst_req", bus.mem_req, 0);
    chk("rst_addr", bus.mem_addr, 0);
    chk("rst_lv", bus.line_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_cnt", bus.fill_count, 0);
    chk("rst_data", bus.line_data, 0);
    reset = 1'b0;
    step();

    // zero-wait fill, then 3 wait cycles per word
    do_fill(32'h8000_0014, 0, 1'b0, 1'b0);
    chk("cnt_one", bus.fill_count, 1);
    do_fill(32'h0000_0000, 3, 1'b0, 1'b0);

    // address change mid-fill with miss held; next fill only after RECOVER
    do_fill(32'h8000_0014, 0, 1'b1, 1'b1);
    do_fill(32'h8000_0100, -1, 1'b0, 1'b0);

    // reset while word 2 is pending
    bus.miss_req  = 1'b1;
    bus.miss_addr = 32'h1234_5678;
    step();
    for (int k = 0; k < 2; k++) begin
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = $urandom;
      step();
    end
    bus.mem_ack = 1'b0;
    step();
    chk("pend_req", bus.mem_req, 1);
    chk("pend_addr", bus.mem_addr, 32'h1234_5678);
    #2 reset = 1'b1;
    #1;
    chk("arst_req", bus.mem_req, 0);
    chk("arst_cnt", bus.fill_count, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_data", bus.line_data, 0);
    bus.miss_req = 1'b0;
    @(negedge clk);
    reset         = 1'b0;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hDEAD_BEEF;
    step();
    chk("late_ack_req", bus.mem_req, 0);
    chk("late_ack_busy", bus.busy, 0);
    chk("late_ack_data", bus.line_data, 0);
    bus.mem_ack = 1'b0;
    exp_cnt = '0;
    for (int k = 0; k < LW; k++) exp_line[k] = '0;
    do_fill(32'h1234_5678, 0, 1'b0, 1'b0);

    // back-to-back misses with miss_req held across the first fill
    do_fill(32'h8000_0004, 0, 1'b0, 1'b1);
    do_fill(32'h8000_0020, 0, 1'b0, 1'b0);

    // counter wrap (CNT_W=2) and top-of-memory line
    do_fill(32'hFFFF_FFF8, 1, 1'b0, 1'b0);
    chk("cnt_wrap", bus.fill_count, 0);

    for (int i = 0; i < 8; i++)
      do_fill($urandom, -1, 1'b0, (i < 7) ? 1'($urandom_range(0, 1)) : 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
